// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles big-endian words from a UART byte stream
// and writes them to consecutive word addresses. Optional macro: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int NB     = 32,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_wr_en,
    output logic [NB-1:0]     o_wr_addr,
    output logic [NB-1:0]     o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count
);

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]     HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t          state, next_state;
    logic [1:0]      byte_cnt;
    logic [23:0]     byte_shift;
    logic [NB-1:0]   next_addr;
    logic [31:0]     word;
    logic            word_accept;
    logic            word_fits;
    logic            is_halt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      xor_acc;
`endif

    assign word        = {byte_shift, i_rx_data};
    assign word_accept = (state == RECV) && i_rx_valid && (byte_cnt == 2'd3);
    assign word_fits   = (o_word_count != DEPTH);
    assign is_halt     = (word == HALT_WORD);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (i_start) begin
            next_state = RECV;
        end else begin
            case (state)
                RECV: begin
                    if (word_accept) begin
                        if (!word_fits) begin
                            next_state = ERROR;
                        end else if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                            next_state = CHECK;
`else
                            next_state = DONE;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (i_rx_valid) begin
                        next_state = (i_rx_data == xor_acc) ? DONE : ERROR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Start has priority over a coincident byte, which is dropped.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt     <= '0;
            byte_shift   <= '0;
            next_addr    <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_word_count <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if (i_start) begin
                byte_cnt     <= '0;
                next_addr    <= '0;
                o_word_count <= '0;
            end else if (state == RECV && i_rx_valid) begin
                byte_cnt   <= byte_cnt + 2'd1;
                byte_shift <= {byte_shift[15:0], i_rx_data};
                if (word_accept && word_fits) begin
                    o_wr_en      <= 1'b1;
                    o_wr_addr    <= next_addr;
                    o_wr_data    <= NB'(word);
                    next_addr    <= next_addr + NB'(4);
                    o_word_count <= o_word_count + 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            xor_acc <= '0;
        end else if (i_start) begin
            xor_acc <= '0;
        end else if (state == RECV && i_rx_valid) begin
            xor_acc <= xor_acc ^ i_rx_data;
        end
    end

    assign o_busy = (state == RECV) || (state == CHECK);
`else
    assign o_busy = (state == RECV);
`endif
    assign o_done  = (state == DONE);
    assign o_error = (state == ERROR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (ADDR_W=2); covers LOADER_CHECKSUM_EN when defined.
module tb_instr_mem_loader;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_wr_en;
    logic [31:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [2:0]  o_word_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t exp_q[$];

    // Reference model of the loader's receive path
    bit          m_recv  = 1'b0;
    int          m_bcnt  = 0;
    int          m_count = 0;
    logic [31:0] m_word  = '0;
    logic [31:0] m_addr  = '0;
    logic [7:0]  m_xor   = '0;

    instr_mem_loader #(.NB(32), .ADDR_W(2)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_word_count (o_word_count)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (i_reset && o_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%h data=%h at cycle %0d, required no write",
                         o_wr_addr, o_wr_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (o_wr_addr !== e.addr || o_wr_data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                             o_wr_addr, o_wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_start();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        m_recv  = 1'b1;
        m_bcnt  = 0;
        m_count = 0;
        m_addr  = '0;
        m_xor   = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (m_recv) begin
            m_word = {m_word[23:0], b};
            m_xor  = m_xor ^ b;
            m_bcnt++;
            if (m_bcnt == 4) begin
                m_bcnt = 0;
                if (m_count < 4) begin
                    wr_t e;
                    e.addr = m_addr;
                    e.data = m_word;
                    e.cyc  = cyc + 1;
                    exp_q.push_back(e);
                    m_addr = m_addr + 32'd4;
                    m_count++;
                    if (m_word == 32'hFFFF_FFFF) m_recv = 1'b0;
                end else begin
                    m_recv = 1'b0;
                end
            end
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name, input logic busy, input logic done,
                                input logic err, input logic [2:0] cnt);
        checks++;
        if (o_busy !== busy || o_done !== done || o_error !== err || o_word_count !== cnt) begin
            failures++;
            $display("FAIL %s: got busy=%b done=%b error=%b count=%0d, required busy=%b done=%b error=%b count=%0d",
                     name, o_busy, o_done, o_error, o_word_count, busy, done, err, cnt);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_wr_en !== 1'b0 || o_wr_addr !== '0 || o_wr_data !== '0) begin
            failures++;
            $display("FAIL reset_write_port: got en=%b addr=%h data=%h, required 0", o_wr_en, o_wr_addr, o_wr_data);
        end
        check_status("reset_status", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_normal_load();
        do_start();
        check_status("start_busy", 1'b1, 1'b0, 1'b0, 3'd0);
        send_word(32'h2008_0005);
        send_word(32'hFFFF_FFFF);
        // HALT write is visible now; status must have moved on the same edge
        checks++;
        if (o_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL halt_wr_en: got %b, required 1", o_wr_en);
        end
`ifdef LOADER_CHECKSUM_EN
        check_status("halt_status", 1'b1, 1'b0, 1'b0, 3'd2);
        send_byte(m_xor);
        check_status("checksum_ok_status", 1'b0, 1'b1, 1'b0, 3'd2);
`else
        check_status("halt_status", 1'b0, 1'b1, 1'b0, 3'd2);
`endif
        send_word(32'h1234_5678);
        drain("normal");
        check_status("done_ignores_rx", 1'b0, 1'b1, 1'b0, 3'd2);
    endtask

    task automatic test_reset_midload();
        do_start();
        send_byte(8'hAB);
        send_byte(8'hCD);
        #2;
        i_reset = 1'b0;
        m_recv  = 1'b0;
        #1;
        checks++;
        if (o_wr_en !== 1'b0 || o_wr_addr !== '0 || o_wr_data !== '0) begin
            failures++;
            $display("FAIL async_reset_write_port: got en=%b addr=%h data=%h, required 0",
                     o_wr_en, o_wr_addr, o_wr_data);
        end
        check_status("async_reset_status", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        send_word(32'h0102_0304);
        drain("post_reset");
        check_status("post_reset_idle", 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_back_to_back();
        do_start();
        send_word(32'h1111_2222);
        send_word(32'h3333_4444);
        send_word(32'h5555_6666);
        drain("back_to_back");
        check_status("back_to_back_status", 1'b1, 1'b0, 1'b0, 3'd3);
    endtask

    task automatic test_restart();
        do_start();
        send_byte(8'h77);
        send_byte(8'h88);
        do_start();
        send_word(32'h0000_0001);
        drain("restart");
        check_status("restart_status", 1'b1, 1'b0, 1'b0, 3'd1);
    endtask

    task automatic test_start_drops_byte();
        do_start();
        send_byte(8'h99);
        i_start = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'hEE;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_rx_valid = 1'b0;
        m_recv = 1'b1; m_bcnt = 0; m_count = 0; m_addr = '0; m_xor = '0;
        send_word(32'hA1B2_C3D4);
        drain("start_wins");
        check_status("start_wins_status", 1'b1, 1'b0, 1'b0, 3'd1);
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < 4; i++) send_word(32'h1000_0000 + i);
        check_status("full_status", 1'b1, 1'b0, 1'b0, 3'd4);
        send_word(32'hDEAD_BEEF);
        check_status("overflow_error", 1'b0, 1'b0, 1'b1, 3'd4);
        drain("overflow");
        do_start();
        check_status("error_cleared", 1'b1, 1'b0, 1'b0, 3'd0);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_start();
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        send_byte(8'h01);
        drain("checksum_match");
        check_status("checksum_match_status", 1'b0, 1'b1, 1'b0, 3'd2);
        do_start();
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        send_byte(8'h00);
        drain("checksum_mismatch");
        check_status("checksum_mismatch_status", 1'b0, 1'b0, 1'b1, 3'd2);
    endtask
`endif

    initial begin
        test_reset();
        test_normal_load();
        test_reset_midload();
        test_back_to_back();
        test_restart();
        test_start_drops_byte();
        test_overflow();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
